// File: rtl/ahb_lite_req_arbiter.sv
// ahb_lite_req_arbiter: round-robin share of one AHB-Lite master port
// between NUM_REQ local requesters, one SINGLE transfer at a time.
module ahb_lite_req_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int AHB_ADDR_WIDTH = 32,
    parameter int AHB_DATA_WIDTH = 32
) (
    input  logic                              HCLK,
    input  logic                              HRESETn,
    input  logic [NUM_REQ-1:0]                req_valid,
    output logic [NUM_REQ-1:0]                req_ready,
    input  logic [NUM_REQ-1:0]                req_write,
    input  logic [NUM_REQ*AHB_ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*AHB_DATA_WIDTH-1:0] req_wdata,
    input  logic [NUM_REQ*3-1:0]              req_size,
    output logic [NUM_REQ-1:0]                rsp_valid,
    output logic [AHB_DATA_WIDTH-1:0]         rsp_rdata,
    output logic                              rsp_err,
    output logic                              HSEL,
    output logic [AHB_ADDR_WIDTH-1:0]         HADDR,
    output logic [1:0]                        HTRANS,
    output logic                              HWRITE,
    output logic [2:0]                        HSIZE,
    output logic [2:0]                        HBURST,
    output logic                              HMASTLOCK,
    output logic [3:0]                        HPROT,
    output logic [AHB_DATA_WIDTH-1:0]         HWDATA,
    input  logic [AHB_DATA_WIDTH-1:0]         HRDATA,
    input  logic                              HREADY,
    input  logic                              HRESP
);

    localparam int AW = AHB_ADDR_WIDTH;
    localparam int DW = AHB_DATA_WIDTH;
    localparam int IW = $clog2(NUM_REQ);
    localparam logic [2:0] MAX_SIZE = 3'($clog2(DW / 8));
    localparam logic [1:0] T_IDLE   = 2'b00;
    localparam logic [1:0] T_NONSEQ = 2'b10;

    typedef enum logic [1:0] {IDLE, ADDR, DATA, REJ} state_t;

    state_t         state;
    logic [IW-1:0]  rr;
    logic [IW-1:0]  gnt;
    logic [IW-1:0]  own;
    logic           gnt_any;
    logic [NUM_REQ-1:0] gnt_oh;
    logic           l_write;
    logic [DW-1:0]  l_wdata;
    logic           g_write;
    logic [AW-1:0]  g_addr;
    logic [DW-1:0]  g_wdata;
    logic [2:0]     g_size;
    logic [AW-1:0]  g_mask;
    logic           g_legal;

    // Rotating search, starting one past the last winner.
    always_comb begin
        gnt_any = 1'b0;
        gnt     = rr;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!gnt_any &&
                |(req_valid & (NUM_REQ'(1) << ((int'(rr) + k) % NUM_REQ)))) begin
                gnt_any = 1'b1;
                gnt     = IW'((int'(rr) + k) % NUM_REQ);
            end
        end
    end

    assign gnt_oh  = NUM_REQ'(1) << gnt;
    assign g_write = |(req_write & gnt_oh);
    assign g_addr  = AW'(req_addr >> (int'(gnt) * AW));
    assign g_wdata = DW'(req_wdata >> (int'(gnt) * DW));
    assign g_size  = 3'(req_size >> (int'(gnt) * 3));
    assign g_mask  = (AW'(1) << g_size) - AW'(1);
    assign g_legal = (g_size <= MAX_SIZE) && ((g_addr & g_mask) == '0);

    // Accept is gated by reset so nothing is handed over that cannot be latched.
    assign req_ready = (state == IDLE && HRESETn && gnt_any) ? gnt_oh : '0;

    assign HBURST    = 3'b000;
    assign HMASTLOCK = 1'b0;
    assign HPROT     = 4'b0011;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state     <= IDLE;
            rr        <= '0;
            own       <= '0;
            l_write   <= 1'b0;
            l_wdata   <= '0;
            HSEL      <= 1'b0;
            HADDR     <= '0;
            HTRANS    <= T_IDLE;
            HWRITE    <= 1'b0;
            HSIZE     <= 3'b000;
            HWDATA    <= '0;
            rsp_valid <= '0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= '0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            unique case (state)
                IDLE: begin
                    if (gnt_any) begin
                        rr      <= gnt;
                        own     <= gnt;
                        l_write <= g_write;
                        l_wdata <= g_wdata;
                        if (g_legal) begin
                            state  <= ADDR;
                            HSEL   <= 1'b1;
                            HTRANS <= T_NONSEQ;
                            HADDR  <= g_addr;
                            HWRITE <= g_write;
                            HSIZE  <= g_size;
                        end else begin
                            state     <= REJ;
                            rsp_valid <= gnt_oh;
                            rsp_err   <= 1'b1;
                        end
                    end
                end
                REJ: state <= IDLE;
                ADDR: begin
                    if (HREADY) begin
                        state  <= DATA;
                        HSEL   <= 1'b0;
                        HTRANS <= T_IDLE;
                        HWDATA <= l_wdata;
                    end
                end
                DATA: begin
                    if (HREADY) begin
                        state     <= IDLE;
                        rsp_valid <= NUM_REQ'(1) << own;
                        rsp_err   <= HRESP;
                        rsp_rdata <= l_write ? '0 : HRDATA;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_lite_req_arbiter.sv
// Randomised scoreboard bench for ahb_lite_req_arbiter with three
// requesters, a scripted AHB slave and a rule-level reference model.
`timescale 1ns/1ps
module tb_ahb_lite_req_arbiter;
    localparam int NR   = 3;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int NCYC = 4000;

    logic HCLK = 1'b0;
    logic HRESETn = 1'b0;
    logic [NR-1:0]    req_valid, req_ready, req_write, rsp_valid;
    logic [NR*AW-1:0] req_addr;
    logic [NR*DW-1:0] req_wdata;
    logic [NR*3-1:0]  req_size;
    logic [DW-1:0]    rsp_rdata, HWDATA, HRDATA;
    logic             rsp_err, HSEL, HWRITE, HMASTLOCK, HREADY, HRESP;
    logic [AW-1:0]    HADDR;
    logic [1:0]       HTRANS;
    logic [2:0]       HSIZE, HBURST;
    logic [3:0]       HPROT;

    ahb_lite_req_arbiter #(
        .NUM_REQ(NR), .AHB_ADDR_WIDTH(AW), .AHB_DATA_WIDTH(DW)
    ) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_size(req_size),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE),
        .HSIZE(HSIZE), .HBURST(HBURST), .HMASTLOCK(HMASTLOCK),
        .HPROT(HPROT), .HWDATA(HWDATA), .HRDATA(HRDATA),
        .HREADY(HREADY), .HRESP(HRESP)
    );

    always #5 HCLK = ~HCLK;

    int cyc = 0;
    always @(posedge HCLK) cyc <= cyc + 1;

    typedef struct {
        bit            w;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [2:0]    s;
    } rq_t;

    // Slave script for one legal transfer; em: 0 two-cycle ERROR,
    // 1 single-cycle ERROR, otherwise OKAY.
    typedef struct {
        int            g;
        bit            w;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [2:0]    s;
        int            t;
        int            nw;
        int            st;
        int            em;
        logic [DW-1:0] rd;
        bit            rst;
    } sl_t;

    typedef struct {
        int            g;
        bit            err;
        logic [DW-1:0] rd;
        int            due;
    } sb_t;

    rq_t rq [NR];
    bit  pend [NR];
    sl_t slq [$];
    sb_t sbq [$];
    int  rr_m = 0;
    int  busy_until = 0;
    int  n_cmp = 0;
    int  n_bad = 0;
    int  n_rst = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %0h expected %0h",
                     nm, cyc, act, exp);
        end
    endtask

    function automatic int rr_pick(input int rr, input logic [NR-1:0] m);
        for (int k = 1; k <= NR; k++)
            if (((m >> ((rr + k) % NR)) & 1) != 0) return (rr + k) % NR;
        return -1;
    endfunction

    function automatic bit legal(input logic [AW-1:0] a, input logic [2:0] s);
        return (s <= 3'd2) && ((a % (32'd1 << s)) == 0);
    endfunction

    function automatic rq_t gen();
        rq_t r;
        r.w = 1'($urandom_range(0, 1));
        r.d = $urandom;
        r.s = 3'($urandom_range(0, 2));
        r.a = $urandom & 32'h0000_0FFC;
        case ($urandom_range(0, 9))
            0: r.s = 3'($urandom_range(3, 7));
            1: r.a = r.a | 32'($urandom_range(1, 3));
            default: ;
        endcase
        return r;
    endfunction

    task automatic check_reset_outs();
        chk("rst_ctl", {HSEL, HTRANS, HWRITE, HSIZE, rsp_valid, rsp_err,
                        req_ready}, 64'd0);
        chk("rst_bus", {HADDR, HWDATA}, 64'd0);
        chk("rst_rdata", rsp_rdata, 64'd0);
        chk("rst_const", {HBURST, HMASTLOCK, HPROT}, {3'b000, 1'b0, 4'b0011});
    endtask

    task automatic slave();
        sl_t e;
        bit  gone;
        forever begin
            @(posedge HCLK); #1;
            if (HTRANS == 2'b10 || HSEL) begin
                if (slq.size() == 0) begin
                    chk("unexpected_nonseq", {HSEL, HTRANS}, 64'd0);
                end else begin
                    e = slq.pop_front();
                    chk("nonseq_cycle", cyc, e.t + 1);
                    chk("addr_phase",
                        {HSEL, HTRANS, HWRITE, HSIZE, HBURST, HMASTLOCK, HPROT},
                        {1'b1, 2'b10, e.w, e.s, 3'b000, 1'b0, 4'b0011});
                    chk("haddr", HADDR, e.a);
                    repeat (e.st) begin
                        HREADY = 1'b0;
                        @(posedge HCLK); #1;
                        chk("addr_hold", {HSEL, HTRANS, HADDR}, {1'b1, 2'b10, e.a});
                    end
                    HREADY = 1'b1;
                    @(posedge HCLK); #1;
                    gone = 1'b0;
                    for (int k = 0; k < e.nw; k++) begin
                        chk("data_phase", {HSEL, HTRANS}, 64'd0);
                        if (e.w) chk("hwdata", HWDATA, e.d);
                        if (e.rst) begin
                            HRESETn = 1'b0;
                            HREADY  = 1'b1;
                            #1;
                            check_reset_outs();
                            sbq.delete(sbq.size() - 1);
                            rr_m = 0;
                            @(posedge HCLK); #1;
                            HRESETn = 1'b1;
                            busy_until = cyc;
                            gone = 1'b1;
                            break;
                        end
                        HREADY = 1'b0;
                        @(posedge HCLK); #1;
                    end
                    if (!gone) begin
                        chk("data_phase", {HSEL, HTRANS}, 64'd0);
                        if (e.w) chk("hwdata", HWDATA, e.d);
                        if (e.em == 0) begin
                            HREADY = 1'b0;
                            HRESP  = 1'b1;
                            @(posedge HCLK); #1;
                            chk("err_first", {HSEL, HTRANS, rsp_valid}, 64'd0);
                        end
                        HREADY = 1'b1;
                        HRESP  = (e.em < 2);
                        HRDATA = e.rd;
                        if (sbq.size() > 0) sbq[sbq.size() - 1].due = cyc + 1;
                        busy_until = cyc + 1;
                        @(posedge HCLK); #1;
                        HRESP  = 1'b0;
                        HRDATA = $urandom;
                    end
                end
            end
        end
    endtask

    task automatic monitor();
        sb_t s;
        forever begin
            @(posedge HCLK); #1;
            if (rsp_valid != '0) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_rsp", rsp_valid, 64'd0);
                end else begin
                    s = sbq.pop_front();
                    chk("rsp_owner", rsp_valid, 64'd1 << s.g);
                    chk("rsp_err", rsp_err, s.err);
                    chk("rsp_rdata", rsp_rdata, s.rd);
                    chk("rsp_cycle", cyc, s.due);
                end
            end else if (rsp_err) begin
                chk("rsp_err_pulse", rsp_err, 64'd0);
            end
        end
    endtask

    initial begin
        logic [NR-1:0] m;
        logic [NR-1:0] exp;
        int g;
        sl_t e;

        for (int i = 0; i < NR; i++) begin
            rq[i] = gen();
            pend[i] = 1'b0;
        end
        req_valid = '1;
        req_write = '0;
        req_addr  = '0;
        req_wdata = '0;
        req_size  = '0;
        HREADY = 1'b1;
        HRESP  = 1'b0;
        HRDATA = '0;

        repeat (3) @(posedge HCLK);
        #1;
        check_reset_outs();
        req_valid = '0;
        HRESETn = 1'b1;

        fork
            slave();
            monitor();
        join_none

        for (int c = 0; c < NCYC + 60; c++) begin
            @(posedge HCLK); #1;
            for (int i = 0; i < NR; i++) begin
                if (c >= NCYC) begin
                    pend[i] = 1'b0;
                end else if (!pend[i] && $urandom_range(0, 3) == 0) begin
                    pend[i] = 1'b1;
                    rq[i] = gen();
                end else if (pend[i] && $urandom_range(0, 29) == 0) begin
                    pend[i] = 1'b0;
                end
                req_valid[i] = pend[i];
                req_write[i] = rq[i].w;
                req_addr[i*AW +: AW]  = rq[i].a;
                req_wdata[i*DW +: DW] = rq[i].d;
                req_size[i*3 +: 3]    = rq[i].s;
            end
            #1;
            m = req_valid;
            exp = '0;
            g = -1;
            if (HRESETn && cyc >= busy_until && m != '0) begin
                g = rr_pick(rr_m, m);
                exp = NR'(1) << g;
            end
            if (m != '0 || req_ready != '0) chk("req_ready", req_ready, exp);
            if (g >= 0) begin
                rr_m = g;
                pend[g] = 1'b0;
                if (legal(rq[g].a, rq[g].s)) begin
                    e.g  = g;
                    e.w  = rq[g].w;
                    e.a  = rq[g].a;
                    e.d  = rq[g].d;
                    e.s  = rq[g].s;
                    e.t  = cyc;
                    e.nw = $urandom_range(0, 3);
                    e.st = ($urandom_range(0, 4) == 0) ? 1 : 0;
                    e.em = $urandom_range(0, 5);
                    e.rd = $urandom;
                    e.rst = (e.nw > 0) &&
                            ((n_rst == 0 && cyc > 200) ||
                             $urandom_range(0, 49) == 0);
                    if (e.rst) n_rst++;
                    slq.push_back(e);
                    sbq.push_back('{g: g, err: (e.em < 2),
                                    rd: (e.w ? '0 : e.rd), due: -1});
                    busy_until = 32'h7fff_ffff;
                end else begin
                    sbq.push_back('{g: g, err: 1'b1, rd: '0, due: cyc + 1});
                    busy_until = cyc + 2;
                end
            end
        end

        chk("sb_drained", sbq.size(), 64'd0);
        chk("slave_drained", slq.size(), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
